// File: rtl/ias_instr_sequencer_if.sv
// Bus between the IAS instruction sequencer and its environment: program-load
// port, run control, IAS instruction/result signals and status outputs.
`timescale 1ns/1ps
interface ias_instr_sequencer_if #(
  parameter int PC_W = 4
);
  logic            prog_we;
  logic [PC_W-1:0] prog_addr;
  logic [7:0]      prog_opcode;
  logic [7:0]      prog_address;
  logic [7:0]      prog_data;
  logic            start;
  logic            abort;
  logic [7:0]      result_in;
  logic [7:0]      opcode;
  logic [7:0]      address;
  logic [7:0]      data_in;
  logic            instr_valid;
  logic            busy;
  logic            done;
  logic [PC_W-1:0] pc_out;
  logic [7:0]      last_result;

  modport master (
    output prog_we, prog_addr, prog_opcode, prog_address, prog_data,
    output start, abort, result_in,
    input  opcode, address, data_in, instr_valid, busy, done, pc_out, last_result
  );

  modport slave (
    input  prog_we, prog_addr, prog_opcode, prog_address, prog_data,
    input  start, abort, result_in,
    output opcode, address, data_in, instr_valid, busy, done, pc_out, last_result
  );
endinterface

// File: rtl/ias_instr_sequencer.sv
// Replays a small stored program onto the IAS core inputs, holding each entry
// for HOLD_CYCLES+1 clocks and capturing the core result at the end of each window.
`timescale 1ns/1ps
module ias_instr_sequencer #(
  parameter int         PROG_DEPTH  = 16,
  parameter int         PC_W        = 4,
  parameter int         HOLD_CYCLES = 3,     // must be >= 1
  parameter logic [7:0] HALT_OP     = 8'hFF
) (
  input logic                  clk,
  input logic                  reset,
  ias_instr_sequencer_if.slave bus
);

  localparam int              CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] address;
    logic [7:0] data;
  } entry_t;

  entry_t           mem [PROG_DEPTH];
  entry_t           cur_entry;
  logic             mem_we;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           out_q, out_d;
  logic             iv_q, iv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       result_q, result_d;

  assign mem_we    = (state_q == S_IDLE) && bus.prog_we;
  assign cur_entry = mem[pc_q];

  // NOTE: the program store has no reset so it maps onto plain RAM; a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.prog_addr] <= '{opcode: bus.prog_opcode, address: bus.prog_address, data: bus.prog_data};
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    iv_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        out_d  = '0;
        busy_d = 1'b0;
        pc_d   = '0;
        // A program write in the same cycle wins over start.
        if (bus.start && !bus.prog_we) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
        end
      end

      S_ISSUE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          out_d   = '0;
          busy_d  = 1'b0;
          pc_d    = '0;
        end else if (cur_entry.opcode == HALT_OP) begin
          state_d = S_DONE;
          out_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
          out_d   = cur_entry;
          iv_d    = 1'b1;
          cnt_d   = CNT_LOAD;
        end
      end

      S_HOLD: begin
        // Abort wins even on the edge that would close the window.
        if (bus.abort) begin
          state_d = S_IDLE;
          out_d   = '0;
          busy_d  = 1'b0;
          pc_d    = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = bus.result_in;
          if (pc_q == PC_LAST) begin
            state_d = S_DONE;
            out_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            pc_d    = pc_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      iv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      iv_q     <= iv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.opcode      = out_q.opcode;
  assign bus.address     = out_q.address;
  assign bus.data_in     = out_q.data;
  assign bus.instr_valid = iv_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pc_out      = pc_q;
  assign bus.last_result = result_q;

endmodule
